// File: rtl/timer_irq_pkg.sv
// Shared constants for the compare timer: register map, CTRL bit positions
// and the controller state encoding.
package timer_irq_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_COMPARE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT    = 2'd3;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_PENDING = 2;
    localparam int CTRL_OVERRUN = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIRED = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: emits a one-cycle tick every max(divisor,1) cycles
// while run is high; clear restarts the division from zero.
module tick_prescaler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             run,
    input  logic             clear,
    input  logic [CNT_W-1:0] divisor,
    output logic             tick
);

    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] term;

    // A divisor of 0 behaves like 1 (tick every running cycle).
    always_comb begin
        term = '0;
        if (divisor != '0) begin
            term = divisor - CNT_W'(1);
        end
    end

    assign tick = run && (pcnt_q == term);

    always_ff @(posedge clk) begin
        if (rst_p || clear) begin
            pcnt_q <= '0;
        end else if (run) begin
            pcnt_q <= tick ? '0 : pcnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Compare timer with level interrupt and optional overrun flag
// (overrun tracking built only when TIMER_IRQ_OVERRUN_EN is defined).
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic [CNT_W-1:0] cfg_rdata,
    input  logic             irq_ack,
    output logic             irq,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic             reload_q;
    logic [CNT_W-1:0] prescale_q, compare_q, count_q;
    logic             irq_q;
    logic             overrun;
    logic             tick, match, run, clear;
    logic             wr_ctrl, wr_prescale, wr_compare, wr_count;

    assign wr_ctrl     = cfg_we && (cfg_addr == ADDR_CTRL);
    assign wr_prescale = cfg_we && (cfg_addr == ADDR_PRESCALE);
    assign wr_compare  = cfg_we && (cfg_addr == ADDR_COMPARE);
    assign wr_count    = cfg_we && (cfg_addr == ADDR_COUNT);

    assign run   = (state_q == ST_RUN);
    assign match = tick && (count_q == compare_q);
    // Restart the divider when (re)arming from a stopped state or when COUNT is rewritten.
    assign clear = (wr_ctrl && cfg_wdata[CTRL_ENABLE] && !run) || wr_count;

    tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk     (clk),
        .rst_p   (rst_p),
        .run     (run),
        .clear   (clear),
        .divisor (prescale_q),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A CTRL write always wins over the match-driven RUN->FIRED transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && cfg_wdata[CTRL_ENABLE]) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wr_ctrl) begin
                    state_d = cfg_wdata[CTRL_ENABLE] ? ST_RUN : ST_IDLE;
                end else if (match && !reload_q) begin
                    state_d = ST_FIRED;
                end
            end
            ST_FIRED: begin
                if (wr_ctrl) state_d = cfg_wdata[CTRL_ENABLE] ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            reload_q   <= 1'b0;
            prescale_q <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_ctrl)     reload_q   <= cfg_wdata[CTRL_RELOAD];
            if (wr_prescale) prescale_q <= cfg_wdata;
            if (wr_compare)  compare_q  <= cfg_wdata;
            if (wr_count) begin
                count_q <= '0;
            end else if (tick) begin
                count_q <= match ? '0 : count_q + CNT_W'(1);
            end
            if (match) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

`ifdef TIMER_IRQ_OVERRUN_EN
    logic overrun_q;

    // Clearing by W1C takes priority over a coincident overrun event.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            overrun_q <= 1'b0;
        end else if (wr_ctrl && cfg_wdata[CTRL_OVERRUN]) begin
            overrun_q <= 1'b0;
        end else if (match && irq_q && !irq_ack) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_CTRL: begin
                cfg_rdata[CTRL_ENABLE]  = run;
                cfg_rdata[CTRL_RELOAD]  = reload_q;
                cfg_rdata[CTRL_PENDING] = irq_q;
                cfg_rdata[CTRL_OVERRUN] = overrun;
            end
            ADDR_PRESCALE: cfg_rdata = prescale_q;
            ADDR_COMPARE:  cfg_rdata = compare_q;
            default:       cfg_rdata = count_q;
        endcase
    end

    assign irq       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: reset, periodic/one-shot matches, ack
// races, overrun, reset during RUN and COUNT rewrite.
module tb_timer_irq_ctrl;
    import timer_irq_pkg::*;

    localparam int CNT_W = 32;

`ifdef TIMER_IRQ_OVERRUN_EN
    localparam logic [CNT_W-1:0] CTRL_HELD = 32'hF;
`else
    localparam logic [CNT_W-1:0] CTRL_HELD = 32'h7;
`endif

    logic             clk = 1'b0;
    logic             rst_p;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;
    logic [CNT_W-1:0] cfg_rdata;
    logic             irq_ack;
    logic             irq;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int n;
    logic [CNT_W-1:0] exp_q[$];

    // clock / reset
    always #10 clk = ~clk;

    timer_irq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_ack   (irq_ack),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int cnt);
        for (int i = 0; i < cnt; i++) step();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [CNT_W-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        step();
        rst_p = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic wait_irq(input int max_cyc, output int cnt);
        cnt = 0;
        while (irq !== 1'b1 && cnt < max_cyc) begin
            step();
            cnt++;
        end
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [CNT_W-1:0] exp);
        cfg_addr = a;
        #1;
        check(tag, cfg_rdata, exp);
    endtask

    initial begin
        rst_p     = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = ADDR_CTRL;
        cfg_wdata = '0;
        irq_ack   = 1'b0;
        steps(2);
        rst_p = 1'b0;

        check("rst_irq", {31'b0, irq}, 0);
        check("rst_state", {30'b0, dbg_state}, ST_IDLE);
        check_reg("rst_ctrl", ADDR_CTRL, 0);
        check_reg("rst_prescale", ADDR_PRESCALE, 0);
        check_reg("rst_compare", ADDR_COMPARE, 0);
        check_reg("rst_count", ADDR_COUNT, 0);

        // periodic: (2+1)*4 = 12 cycles per match
        cfg_write(ADDR_PRESCALE, 4);
        cfg_write(ADDR_COMPARE, 2);
        for (int k = 0; k < 3; k++) exp_q.push_back(12);
        cfg_write(ADDR_CTRL, 32'h3);
        check("per_state", {30'b0, dbg_state}, ST_RUN);
        wait_irq(40, n);
        check("per_first", n, exp_q.pop_front());
        check_reg("per_count_zero", ADDR_COUNT, 0);
        for (int k = 0; k < 2; k++) begin
            pulse_ack();
            check("per_ack_clear", {31'b0, irq}, 0);
            wait_irq(40, n);
            check("per_period", n + 1, exp_q.pop_front());
        end
        pulse_ack();
        cfg_write(ADDR_CTRL, 32'h0);
        check("per_disable_state", {30'b0, dbg_state}, ST_IDLE);
        check_reg("per_disable_ctrl", ADDR_CTRL, 0);

        // one-shot: 4 cycles, then FIRED with COUNT frozen
        do_reset();
        cfg_write(ADDR_PRESCALE, 1);
        cfg_write(ADDR_COMPARE, 3);
        cfg_write(ADDR_CTRL, 32'h1);
        wait_irq(20, n);
        check("os_latency", n, 4);
        check("os_state", {30'b0, dbg_state}, ST_FIRED);
        check_reg("os_ctrl", ADDR_CTRL, 32'h4);
        check_reg("os_count", ADDR_COUNT, 0);
        steps(5);
        check_reg("os_count_held", ADDR_COUNT, 0);
        check("os_state_held", {30'b0, dbg_state}, ST_FIRED);
        check("os_irq_held", {31'b0, irq}, 1);

        // ack coinciding with a match keeps irq high
        do_reset();
        cfg_write(ADDR_PRESCALE, 1);
        cfg_write(ADDR_COMPARE, 0);
        cfg_write(ADDR_CTRL, 32'h3);
        wait_irq(10, n);
        check("race_latency", n, 1);
        pulse_ack();
        check("race_irq", {31'b0, irq}, 1);
        check_reg("race_ctrl", ADDR_CTRL, 32'h7);

        // withheld ack for two periods of 4 cycles
        do_reset();
        cfg_write(ADDR_PRESCALE, 2);
        cfg_write(ADDR_COMPARE, 1);
        cfg_write(ADDR_CTRL, 32'h3);
        wait_irq(20, n);
        check("ovr_latency", n, 4);
        steps(8);
        check_reg("ovr_ctrl_set", ADDR_CTRL, CTRL_HELD);
        cfg_write(ADDR_CTRL, 32'h9);
        check_reg("ovr_ctrl_clr", ADDR_CTRL, 32'h5);
        check("ovr_state", {30'b0, dbg_state}, ST_RUN);

        // reset in the middle of RUN
        do_reset();
        cfg_write(ADDR_PRESCALE, 1);
        cfg_write(ADDR_COMPARE, 20);
        cfg_write(ADDR_CTRL, 32'h1);
        steps(5);
        check_reg("mrst_count_pre", ADDR_COUNT, 5);
        do_reset();
        check("mrst_irq", {31'b0, irq}, 0);
        check("mrst_state", {30'b0, dbg_state}, ST_IDLE);
        check_reg("mrst_ctrl", ADDR_CTRL, 0);
        check_reg("mrst_prescale", ADDR_PRESCALE, 0);
        check_reg("mrst_compare", ADDR_COMPARE, 0);
        check_reg("mrst_count", ADDR_COUNT, 0);

        // COUNT rewrite restarts a full 10-cycle period
        cfg_write(ADDR_PRESCALE, 1);
        cfg_write(ADDR_COMPARE, 9);
        cfg_write(ADDR_CTRL, 32'h3);
        steps(7);
        check_reg("cw_count_pre", ADDR_COUNT, 7);
        cfg_write(ADDR_COUNT, 32'h1234);
        check_reg("cw_count_zero", ADDR_COUNT, 0);
        steps(9);
        check("cw_irq_early", {31'b0, irq}, 0);
        check_reg("cw_count_nine", ADDR_COUNT, 9);
        step();
        check("cw_irq_match", {31'b0, irq}, 1);
        check_reg("cw_count_wrap", ADDR_COUNT, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of count, compare and prescale registers and of the config data bus.
REQ-002 SHALL have port clk  input  1: the block's single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_p  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port cfg_we  input  1: register write strobe, one write per cycle when high.
REQ-005 SHALL have port cfg_addr  input  2: register select; 0=CTRL, 1=PRESCALE, 2=COMPARE, 3=COUNT.
REQ-006 SHALL have port cfg_wdata  input  CNT_W: write data.
REQ-007 SHALL have port cfg_rdata  output  CNT_W: combinational read of the register at cfg_addr.
REQ-008 SHALL have port irq_ack  input  1: single-cycle acknowledge from the interrupt controller.
REQ-009 SHALL have port irq  output  1: level interrupt request, registered.

Function
REQ-010 SHALL implement states IDLE, RUN and FIRED.
REQ-011 SHALL define CTRL as: bit0 ENABLE (RW), bit1 RELOAD (RW), bit2 PENDING (RO, equals irq), bit3 OVERRUN (W1C); other bits read 0.
REQ-012 SHALL transition IDLE->RUN on a CTRL write with bit0=1, clearing the prescale counter to 0 on the same edge.
REQ-013 SHALL transition RUN->IDLE or FIRED->IDLE on a CTRL write with bit0=0; COUNT holds its value and irq is unaffected.
REQ-014 SHALL, in RUN, increment the prescale counter each cycle and raise the internal tick when it equals max(PRESCALE,1)-1, wrapping it to 0 on the same edge.
REQ-015 SHALL, on a tick with COUNT != COMPARE, increment COUNT by 1, modulo 2^CNT_W.
REQ-016 SHALL, on a tick with COUNT == COMPARE (a match), load COUNT with 0 and set irq on the same edge.
REQ-017 SHALL make the match period (COMPARE+1)*max(PRESCALE,1) cycles; COMPARE=0 with PRESCALE<=1 gives a match every cycle.
REQ-018 SHALL, on a match with RELOAD=1, remain in RUN.
REQ-019 SHALL, on a match with RELOAD=0, go to FIRED, clear ENABLE and halt the prescale counter and COUNT.
REQ-020 SHALL hold irq high until irq_ack is sampled high, then clear irq on that edge.
REQ-021 SHALL keep irq high when irq_ack and a match occur in the same cycle.
REQ-022 SHALL, on any COUNT write, load COUNT with 0 regardless of cfg_wdata and clear the prescale counter.
REQ-023 SHALL apply PRESCALE or COMPARE writes made during RUN from the next cycle, with no restart.
REQ-024 SHALL give a register write priority over a simultaneous tick update of the same state.

Reset
REQ-025 SHALL, when rst_p is high at a clock edge, set state=IDLE, irq=0, ENABLE=0, RELOAD=0, OVERRUN=0, PRESCALE=0, COMPARE=0, COUNT=0 and the prescale counter to 0.
REQ-026 SHALL let reset override all config writes and ticks in the same cycle, including reset during RUN or FIRED.

Configuration
REQ-027 SHALL, when TIMER_IRQ_OVERRUN_EN is defined, set OVERRUN on a match while irq is already high and irq_ack is low; OVERRUN is cleared by writing 1 to CTRL bit3.
REQ-028 SHALL, when TIMER_IRQ_OVERRUN_EN is undefined, read OVERRUN as 0, merge repeated matches into the pending irq and contain no overrun logic.

Structure
REQ-029 SHALL place the register address constants, CTRL bit indices and state encodings in the shared package timer_irq_pkg.
REQ-030 SHALL implement the prescaler as the sub-module tick_prescaler (inputs clk, rst_p, run, clear, divisor; output tick).

Verification
REQ-031 SHALL test: PRESCALE=4, COMPARE=2, RELOAD=1, enable -> first irq 12 cycles after the enable edge, then every 12 cycles with ack.
REQ-032 SHALL test: RELOAD=0, PRESCALE=1, COMPARE=3 -> one irq after 4 cycles, state FIRED, CTRL reads 0x4, COUNT stays 0.
REQ-033 SHALL test: irq_ack asserted on the same cycle as the next match (PRESCALE=1, COMPARE=0) -> irq stays 1 and OVERRUN stays 0.
REQ-034 SHALL test: with the macro defined, withhold ack for 2 periods -> OVERRUN=1; then write CTRL=0x9 -> OVERRUN=0 and the block stays in RUN.
REQ-035 SHALL test: rst_p pulsed mid-RUN with COUNT=5 -> next cycle irq=0, COUNT=0, state IDLE, all registers read 0.
REQ-036 SHALL test: a COUNT write during RUN with COUNT=7 -> COUNT=0 and the next match occurs a full period later.
